// File: rtl/sdram_rmw_engine.sv
// Burst read-modify-write over a frame region: read BURST_LEN words, add LANE_INC per lane (saturating under RMW_SATURATE_EN), write back.
// One idle cycle between bursts; beats advance only on i_Data_Read_Valid / i_Data_Write_Done, arbiter is granted only in IDLE.
module sdram_rmw_engine #(
  parameter int DATA_W      = 32,
  parameter int LANE_W      = 8,
  parameter int LANE_INC    = 1,
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 8,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 96000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic              i_SDRAM_Requested,
  output logic              o_SDRAM_Yield,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  input  logic              i_Data_Read_Valid,
  input  logic [DATA_W-1:0] i_Data_Read,
  output logic [DATA_W-1:0] o_Data_Write,
  input  logic              i_Data_Write_Done,
  output logic              o_Frame_Done,
  output logic              o_Busy
);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam int LANES = DATA_W / LANE_W;
  localparam int PTR_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(BASE_ADDR + FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
  localparam logic [PTR_W-1:0]  LAST_CNT = PTR_W'(BURST_LEN - 1);

  if ((longint'(BASE_ADDR) + longint'(FRAME_WORDS)) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("sdram_rmw_engine: BASE_ADDR+FRAME_WORDS does not fit in ADDR_W");
  end
  if ((FRAME_WORDS % BURST_LEN) != 0 || (DATA_W % LANE_W) != 0 || BURST_LEN < 1) begin : g_geom_chk
    $error("sdram_rmw_engine: inconsistent burst/lane geometry");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  beat_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] burst_base;
  logic [ADDR_W-1:0] next_base;
  logic [DATA_W-1:0] burst_buf [BURST_LEN];

  logic start_burst, read_beat, write_beat, last_beat;

  assign start_burst = i_Enable && !i_SDRAM_Requested;
  assign read_beat   = (state == S_READ) && i_Data_Read_Valid;
  assign write_beat  = (state == S_WRITE) && i_Data_Write_Done;
  assign last_beat   = (beat_cnt == '0);
  assign next_base   = burst_base + BURST_A;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_burst) state_nxt = S_READ;
      S_READ:  if (read_beat && last_beat) state_nxt = S_WRITE;
      S_WRITE: if (write_beat && last_beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_Command     = CMD_IDLE;
    o_Busy        = 1'b0;
    o_SDRAM_Yield = 1'b0;
    case (state)
      S_READ:  begin o_Command = CMD_READ;  o_Busy = 1'b1; end
      S_WRITE: begin o_Command = CMD_WRITE; o_Busy = 1'b1; end
      default: o_SDRAM_Yield = i_SDRAM_Requested;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Data_Address <= BASE_A;
      burst_base     <= BASE_A;
      beat_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_Frame_Done   <= 1'b0;
    end else begin
      o_Frame_Done <= 1'b0;
      case (state)
        S_IDLE: if (start_burst) begin
          o_Data_Address <= burst_base;
          beat_cnt       <= LAST_CNT;
          wr_ptr         <= '0;
        end
        S_READ: if (i_Data_Read_Valid) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (last_beat) begin
            o_Data_Address <= burst_base;
            beat_cnt       <= LAST_CNT;
            rd_ptr         <= '0;
          end else begin
            o_Data_Address <= o_Data_Address + ADDR_W'(1);
            beat_cnt       <= beat_cnt - PTR_W'(1);
          end
        end
        S_WRITE: if (i_Data_Write_Done) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          if (last_beat) begin
            // Park the address on the next burst start so IDLE shows where we resume.
            if (next_base == END_A) begin
              burst_base     <= BASE_A;
              o_Data_Address <= BASE_A;
              o_Frame_Done   <= 1'b1;
            end else begin
              burst_base     <= next_base;
              o_Data_Address <= next_base;
            end
          end else begin
            o_Data_Address <= o_Data_Address + ADDR_W'(1);
            beat_cnt       <= beat_cnt - PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (read_beat) burst_buf[wr_ptr] <= i_Data_Read;
  end

`ifdef RMW_SATURATE_EN
  logic [LANE_W:0] lane_sum;
  always_comb begin
    o_Data_Write = '0;
    lane_sum     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = {1'b0, burst_buf[rd_ptr][l*LANE_W +: LANE_W]} + (LANE_W+1)'(LANE_INC);
      o_Data_Write[l*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {LANE_W{1'b1}} : lane_sum[LANE_W-1:0];
    end
  end
`else
  always_comb begin
    o_Data_Write = '0;
    for (int l = 0; l < LANES; l++) begin
      o_Data_Write[l*LANE_W +: LANE_W] = burst_buf[rd_ptr][l*LANE_W +: LANE_W] + LANE_W'(LANE_INC);
    end
  end
`endif

endmodule
